// File: rtl/octave_shift_ctrl.sv
// octave_shift_ctrl
//   Keeps a signed, saturating octave offset for the organ keyboard path.
//   Pressing the step keys moves the offset by one octave. Holding a step
//   key auto-repeats: the first repeat comes after HOLD_CYCLES, and later
//   repeats come every REPEAT_CYCLES. The reset key returns the offset to 0.
//
// Ports
//   clk      in   system clock
//   rst_n    in   synchronous, active-low reset
//   key      in   scan code of the currently held key (8'h00 = none)
//   octave   out  current offset, registered, OCT_W bits signed
//   changed  out  one-cycle pulse on every cycle where octave takes a new value
//   at_max   out  octave == OCT_MAX
//   at_min   out  octave == OCT_MIN
module octave_shift_ctrl #(
   parameter int          OCT_W         = 3,
   parameter int          OCT_MIN       = -2,
   parameter int          OCT_MAX       = 2,
   parameter logic [7:0]  KEY_UP        = 8'h12,
   parameter logic [7:0]  KEY_DOWN      = 8'h59,
   parameter logic [7:0]  KEY_RESET     = 8'h29,
   parameter int          HOLD_CYCLES   = 50_000_000,
   parameter int          REPEAT_CYCLES = 10_000_000,
   parameter int          CNT_W         = 26
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [7:0]               key,
   output logic signed [OCT_W-1:0]  octave,
   output logic                     changed,
   output logic                     at_max,
   output logic                     at_min
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      REPEAT = 2'd2
   } state_t;

   // Limits, widened by one bit so that a step can be compared before it is narrowed
   localparam logic signed [OCT_W:0]   MAX_X     = OCT_MAX[OCT_W:0];
   localparam logic signed [OCT_W:0]   MIN_X     = OCT_MIN[OCT_W:0];
   localparam logic signed [OCT_W-1:0] MAX_O     = OCT_MAX[OCT_W-1:0];
   localparam logic signed [OCT_W-1:0] MIN_O     = OCT_MIN[OCT_W-1:0];
   localparam logic [CNT_W-1:0]        HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]        REPEAT_LD = CNT_W'(REPEAT_CYCLES - 1);

   state_t                    state, state_nxt;
   logic [CNT_W-1:0]          tmr, tmr_nxt;
   logic [7:0]                key_prev;
   logic signed [OCT_W-1:0]   octave_nxt;
   logic                      step_en, step_up, zero_en;

   // One step up or down, computed one bit wider so that it cannot wrap,
   // then clamped to the limits. A step that is already at a limit returns
   // the input value unchanged.
   function automatic logic signed [OCT_W-1:0] sat_step(
      input logic signed [OCT_W-1:0] cur,
      input logic                    up
   );
      logic signed [OCT_W:0] ext;
      logic signed [OCT_W:0] sum;
      ext = {cur[OCT_W-1], cur};
      if (up)
         sum = ext + $signed({{OCT_W{1'b0}}, 1'b1});
      else
         sum = ext - $signed({{OCT_W{1'b0}}, 1'b1});
      if (sum > MAX_X)
         sum = MAX_X;
      if (sum < MIN_X)
         sum = MIN_X;
      return sum[OCT_W-1:0];
   endfunction

   always_comb begin
      state_nxt  = state;
      tmr_nxt    = tmr;
      step_en    = 1'b0;
      step_up    = 1'b0;
      zero_en    = 1'b0;

      if (key == 8'h00) begin
         state_nxt = IDLE;
      end else if (key != key_prev) begin
         // A new code always wins over the timer, so switching codes restarts the timing
         if (key == KEY_UP || key == KEY_DOWN) begin
            step_en   = 1'b1;
            step_up   = (key == KEY_UP);
            tmr_nxt   = HOLD_LD;
            state_nxt = HOLD;
         end else if (key == KEY_RESET) begin
            zero_en   = 1'b1;
            state_nxt = IDLE;
         end else begin
            state_nxt = IDLE;
         end
      end else if (state != IDLE) begin
         // A step key is still held. Only step keys can reach HOLD or REPEAT.
         if (tmr != '0) begin
            tmr_nxt = tmr - 1'b1;
         end else begin
            step_en   = 1'b1;
            step_up   = (key == KEY_UP);
            tmr_nxt   = REPEAT_LD;
            state_nxt = REPEAT;
         end
      end

      octave_nxt = octave;
      if (zero_en)
         octave_nxt = '0;
      else if (step_en)
         octave_nxt = sat_step(octave, step_up);
   end

   // ---- register stage: control and offset update ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         tmr      <= '0;
         key_prev <= 8'h00;
         octave   <= '0;
         changed  <= 1'b0;
      end else begin
         state    <= state_nxt;
         tmr      <= tmr_nxt;
         key_prev <= key;
         octave   <= octave_nxt;
         changed  <= (octave_nxt != octave);
      end
   end

   assign at_max = (octave == MAX_O);
   assign at_min = (octave == MIN_O);

endmodule
